// File: rtl/clock_pkg.sv
// Shared definitions for the clock/timer datapath: BCD digit type,
// digit limits, timer state encoding and the load-value clamp helper.
package clock_pkg;

  localparam int c_DIGIT_W = 4;

  typedef logic [c_DIGIT_W-1:0] bcd_t;

  localparam bcd_t c_BCD_MAX      = 4'd9;
  localparam bcd_t c_SEC_TENS_MAX = 4'd5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_ALARM  = 2'd3
  } timer_state_t;

  // Saturate a BCD digit to the largest value its position may hold.
  function automatic bcd_t clamp_bcd(input bcd_t digit, input bcd_t limit);
    return (digit > limit) ? limit : digit;
  endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Control and display bundle between the timer and its user (buttons,
// tick generator and the 4-digit display mux).
interface countdown_timer_if;
  import clock_pkg::*;

  logic       i_Tick;
  logic       i_Load;
  logic [7:0] i_Load_Min;
  logic [7:0] i_Load_Sec;
  logic       i_Start;
  logic       i_Pause;
  bcd_t       o_Min_Tens;
  bcd_t       o_Min_Ones;
  bcd_t       o_Sec_Tens;
  bcd_t       o_Sec_Ones;
  logic       o_Running;
  logic       o_Alarm;
  logic       o_Zero;

  modport master (
    output i_Tick, i_Load, i_Load_Min, i_Load_Sec, i_Start, i_Pause,
    input  o_Min_Tens, o_Min_Ones, o_Sec_Tens, o_Sec_Ones,
    input  o_Running, o_Alarm, o_Zero
  );

  modport slave (
    input  i_Tick, i_Load, i_Load_Min, i_Load_Sec, i_Start, i_Pause,
    output o_Min_Tens, o_Min_Ones, o_Sec_Tens, o_Sec_Ones,
    output o_Running, o_Alarm, o_Zero
  );

endinterface

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit. Decrements when the borrow from the less
// significant digit arrives, wrapping 0 -> c_WRAP_VALUE and passing a
// borrow on to the next digit.
module bcd_down_digit
  import clock_pkg::*;
#(
  parameter bcd_t c_WRAP_VALUE = c_BCD_MAX
) (
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic i_Enable_Borrow,
  input  logic i_Load,
  input  bcd_t i_Load_Value,
  output bcd_t o_Data,
  output logic o_Borrow
);

  // Digit register: reset, load, then borrow-driven decrement.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      o_Data <= '0;
    end else if (i_Load) begin
      o_Data <= i_Load_Value;
    end else if (i_Enable_Borrow) begin
      if (o_Data == '0) begin
        o_Data <= c_WRAP_VALUE;
      end else begin
        o_Data <= o_Data - 4'd1;
      end
    end
  end

  assign o_Borrow = i_Enable_Borrow & (o_Data == '0);

endmodule

// File: rtl/countdown_timer.sv
// Loadable MM:SS countdown timer: four chained BCD down-digits plus a
// run/pause/alarm controller clocked by the shared 1 Hz tick.
module countdown_timer
  import clock_pkg::*;
#(
  parameter int c_ALARM_TICKS = 10
) (
  input  logic              i_Clock,
  input  logic              i_Reset,
  countdown_timer_if.slave  bus
);

  localparam logic [7:0] c_ALARM_LAST = 8'(c_ALARM_TICKS);

  timer_state_t r_state;
  logic [7:0]   r_alarm_cnt;
  logic         r_running;
  logic         r_alarm;

  bcd_t sec_ones, sec_tens, min_ones, min_tens;
  bcd_t ld_sec_ones, ld_sec_tens, ld_min_ones, ld_min_tens;
  logic dec_en;
  logic borrow_sec_ones, borrow_sec_tens, borrow_min_ones;
  logic unused_borrow_min_tens;
  logic all_zero;
  logic last_second;

  // Out-of-range BCD load digits saturate to the position's maximum.
  assign ld_sec_ones = clamp_bcd(bus.i_Load_Sec[3:0], c_BCD_MAX);
  assign ld_sec_tens = clamp_bcd(bus.i_Load_Sec[7:4], c_SEC_TENS_MAX);
  assign ld_min_ones = clamp_bcd(bus.i_Load_Min[3:0], c_BCD_MAX);
  assign ld_min_tens = clamp_bcd(bus.i_Load_Min[7:4], c_BCD_MAX);

  // A tick only counts while running and not overridden by load or pause.
  assign dec_en = (r_state == ST_RUN) & bus.i_Tick & ~bus.i_Load & ~bus.i_Pause;

  assign all_zero    = (min_tens == '0) && (min_ones == '0) &&
                       (sec_tens == '0) && (sec_ones == '0);
  assign last_second = (min_tens == '0) && (min_ones == '0) &&
                       (sec_tens == '0) && (sec_ones == 4'd1);

  bcd_down_digit #(.c_WRAP_VALUE(c_BCD_MAX)) u_sec_ones (
    .i_Clock         (i_Clock),
    .i_Reset         (i_Reset),
    .i_Enable_Borrow (dec_en),
    .i_Load          (bus.i_Load),
    .i_Load_Value    (ld_sec_ones),
    .o_Data          (sec_ones),
    .o_Borrow        (borrow_sec_ones)
  );

  bcd_down_digit #(.c_WRAP_VALUE(c_SEC_TENS_MAX)) u_sec_tens (
    .i_Clock         (i_Clock),
    .i_Reset         (i_Reset),
    .i_Enable_Borrow (borrow_sec_ones),
    .i_Load          (bus.i_Load),
    .i_Load_Value    (ld_sec_tens),
    .o_Data          (sec_tens),
    .o_Borrow        (borrow_sec_tens)
  );

  bcd_down_digit #(.c_WRAP_VALUE(c_BCD_MAX)) u_min_ones (
    .i_Clock         (i_Clock),
    .i_Reset         (i_Reset),
    .i_Enable_Borrow (borrow_sec_tens),
    .i_Load          (bus.i_Load),
    .i_Load_Value    (ld_min_ones),
    .o_Data          (min_ones),
    .o_Borrow        (borrow_min_ones)
  );

  // Minute tens never borrows: 00:00 is trapped into ALARM first.
  bcd_down_digit #(.c_WRAP_VALUE(c_BCD_MAX)) u_min_tens (
    .i_Clock         (i_Clock),
    .i_Reset         (i_Reset),
    .i_Enable_Borrow (borrow_min_ones),
    .i_Load          (bus.i_Load),
    .i_Load_Value    (ld_min_tens),
    .o_Data          (min_tens),
    .o_Borrow        (unused_borrow_min_tens)
  );

  // Timer controller with registered status outputs.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_state     <= ST_IDLE;
      r_alarm_cnt <= '0;
      r_running   <= 1'b0;
      r_alarm     <= 1'b0;
    end else if (bus.i_Load) begin
      r_state     <= ST_IDLE;
      r_alarm_cnt <= '0;
      r_running   <= 1'b0;
      r_alarm     <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (bus.i_Start && !all_zero) begin
            r_state   <= ST_RUN;
            r_running <= 1'b1;
          end
        end
        ST_RUN: begin
          if (bus.i_Pause) begin
            r_state   <= ST_PAUSED;
            r_running <= 1'b0;
          end else if (bus.i_Tick && last_second) begin
            r_state     <= ST_ALARM;
            r_alarm_cnt <= '0;
            r_running   <= 1'b0;
            r_alarm     <= 1'b1;
          end
        end
        ST_PAUSED: begin
          if (!bus.i_Pause && bus.i_Start) begin
            r_state   <= ST_RUN;
            r_running <= 1'b1;
          end
        end
        ST_ALARM: begin
          if (bus.i_Start) begin
            r_state <= ST_IDLE;
            r_alarm <= 1'b0;
          end else if (bus.i_Tick) begin
            r_alarm_cnt <= r_alarm_cnt + 8'd1;
            if ((r_alarm_cnt + 8'd1) == c_ALARM_LAST) begin
              r_state <= ST_IDLE;
              r_alarm <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  assign bus.o_Min_Tens = min_tens;
  assign bus.o_Min_Ones = min_ones;
  assign bus.o_Sec_Tens = sec_tens;
  assign bus.o_Sec_Ones = sec_ones;
  assign bus.o_Running  = r_running;
  assign bus.o_Alarm    = r_alarm;
  assign bus.o_Zero     = all_zero;

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Loadable MM:SS countdown timer built from cascaded BCD down-counting digits with a borrow chain, the decrementing counterpart of the clock's up-counting carry-chain digits.
- Driven by the shared 1 Hz enable tick.
- Provides run/pause/alarm control for the clock's timer mode.
- Drives the same 4-digit display mux as the time-of-day counters.

Parameters:
- c_ALARM_TICKS, 10: number of i_Tick pulses o_Alarm stays high before auto-return to IDLE. Legal range is 1..255.

Ports:
- i_Clock  input  1  system clock
- i_Reset  input  1  synchronous, active-high reset
- i_Tick  input  1  one-cycle enable pulse, 1 Hz
- i_Load  input  1  one-cycle pulse: load i_Load_Min/i_Load_Sec
- i_Load_Min  input  8  BCD minutes {tens, ones}
- i_Load_Sec  input  8  BCD seconds {tens, ones}
- i_Start  input  1  one-cycle pulse: start/resume, or acknowledge alarm
- i_Pause  input  1  one-cycle pulse: pause
- o_Min_Tens  output  4  BCD digit, 0..9
- o_Min_Ones  output  4  BCD digit, 0..9
- o_Sec_Tens  output  4  BCD digit, 0..5
- o_Sec_Ones  output  4  BCD digit, 0..9
- o_Running  output  1  high in RUN
- o_Alarm  output  1  high in ALARM
- o_Zero  output  1  combinational: all four digits == 0

Behaviour:
- Clock and reset:
  - Clock is i_Clock.
  - Reset is i_Reset, synchronous, active-high.
  - Reset values: all digits 0, state IDLE, alarm tick counter 0, o_Running=0, o_Alarm=0, o_Zero=1.
- Timing:
  - All state and digit registers update on the edge where inputs are sampled.
  - Effect is visible at the outputs the next cycle, i.e. 1-cycle latency.
- States and encoding: IDLE=0, RUN=1, PAUSED=2, ALARM=3.
- Per-cycle priority: i_Reset > i_Load > i_Pause > i_Start > i_Tick.
- Load (any state):
  - Digits take the clamped load value; state -> IDLE; alarm counter cleared.
  - A coincident i_Tick is ignored: no decrement.
- Load clamping:
  - Any digit >9 becomes 9.
  - Sec tens >5 becomes 5.
  - Example: 0x7A / 0x6F loads as 79:59.
- IDLE:
  - i_Start with o_Zero=0 -> RUN.
  - i_Start with o_Zero=1 is ignored.
  - i_Tick and i_Pause are ignored.
- RUN:
  - i_Pause -> PAUSED; a coincident tick does not decrement.
  - i_Start is ignored.
  - i_Tick decrements the time by one second.
  - If the decrement produces 00:00, state -> ALARM on the same edge and the alarm counter is cleared.
- Decrement / borrow chain:
  - Sec ones: 0 -> 9 with borrow, otherwise -1.
  - Sec tens: decrements only on borrow-in; 0 -> 5 with borrow.
  - Min ones: decrements only on borrow-in; 0 -> 9 with borrow.
  - Min tens: decrements only on borrow-in; never below 0, since 00:00 is caught before the next tick.
  - Examples: 10:00 -> 09:59; 01:00 -> 00:59.
- PAUSED:
  - Digits hold; ticks are ignored.
  - i_Start -> RUN; the next tick decrements.
  - i_Start and i_Pause in the same cycle: Pause wins, state stays PAUSED.
- ALARM:
  - o_Alarm=1; digits hold at 00:00.
  - Each i_Tick increments the alarm counter.
  - On the tick that makes the count reach c_ALARM_TICKS -> IDLE.
  - i_Start in ALARM -> IDLE immediately (silence).
  - i_Pause is ignored.
- Output definitions: o_Running = (state==RUN); o_Alarm = (state==ALARM).
- Reset mid-RUN or mid-ALARM: forces reset values on the next edge; there is no partial decrement.

Decomposition:
- Shared package (clock_pkg) holds:
  - state encodings IDLE/RUN/PAUSED/ALARM;
  - BCD limits c_BCD_MAX=9 and c_SEC_TENS_MAX=5;
  - the 4-bit BCD digit width.
- Sub-module bcd_down_digit:
  - Parameter c_WRAP_VALUE.
  - Ports: i_Clock, i_Reset, i_Enable_Borrow, i_Load, i_Load_Value, o_Data, o_Borrow.
  - o_Borrow = i_Enable_Borrow & (o_Data==0).
  - Four instances are chained borrow-out -> enable-in.
  - Clamping of the load value is done in the top level.

Test Plan:
1. Reset asserted 2 cycles -> digits 00:00, o_Zero=1, o_Running=0, o_Alarm=0.
2. Load 0x10/0x00, Start, 1 tick -> 09:59; next tick -> 09:58; o_Running=1 throughout.
3. Load 00:02, Start, 2 ticks -> 00:00, o_Alarm=1, o_Running=0. After 10 further ticks, o_Alarm=0 and state IDLE. Repeat with Start on the 3rd alarm tick -> o_Alarm=0 the next cycle.
4. Pause and resume:
   - Load 00:30, Start, tick -> 00:29.
   - Pause, 5 ticks -> still 00:29.
   - Start+Pause same cycle -> stays paused.
   - Start, tick -> 00:28.
5. Load 0x7A/0x6F -> 79:59. Start with 00:00 loaded -> stays IDLE, o_Running=0.
6. Load 05:00 while in RUN, coincident with a tick -> 05:00, state IDLE, no decrement. Reset during ALARM -> all reset values next cycle.
